// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and the line/frame
// total helper used by the raster generator.
package vga_pkg;

  typedef struct packed {
    logic [15:0] sync;
    logic [15:0] bp;
    logic [15:0] active;
    logic [15:0] fp;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_800X600_60 = '{
    h: '{sync: 16'd128, bp: 16'd88, active: 16'd800, fp: 16'd40},
    v: '{sync: 16'd4,   bp: 16'd23, active: 16'd600, fp: 16'd1}
  };

  localparam vga_mode_t VGA_640X480_60 = '{
    h: '{sync: 16'd96, bp: 16'd48, active: 16'd640, fp: 16'd16},
    v: '{sync: 16'd2,  bp: 16'd33, active: 16'd480, fp: 16'd10}
  };

  function automatic int timing_total(input vga_timing_t t);
    return int'(t.sync) + int'(t.bp) + int'(t.active) + int'(t.fp);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear; DEPTH=0 is a
// plain wire so the caller's output register alone sets the latency.
module vga_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge vga_clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: H/V counters, pixel requests to a
// fixed-latency source, and sync/blank delayed to stay aligned with RGB.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 40,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int PIX_LATENCY = 2,
  parameter int CNT_W       = 11
) (
  input  logic             vga_clk,
  input  logic             resetn,
  input  logic [7:0]       pix_r,
  input  logic [7:0]       pix_g,
  input  logic [7:0]       pix_b,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             req_valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic             VGA_CLK
);

  localparam vga_timing_t H_TIM = '{sync: 16'(H_SYNC), bp: 16'(H_BP),
                                    active: 16'(H_ACTIVE), fp: 16'(H_FP)};
  localparam vga_timing_t V_TIM = '{sync: 16'(V_SYNC), bp: 16'(V_BP),
                                    active: 16'(V_ACTIVE), fp: 16'(V_FP)};
  localparam int H_TOTAL = timing_total(H_TIM);
  localparam int V_TOTAL = timing_total(V_TIM);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_ACT_N  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_N  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_N = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_N = CNT_W'(V_SYNC);
  localparam logic             HS_ON    = 1'(HS_POL);
  localparam logic             VS_ON    = 1'(VS_POL);

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W) ||
      PIX_LATENCY < 0 || PIX_LATENCY > 8) begin : g_param_check
    $error("vga_timing_gen: totals must fit CNT_W and PIX_LATENCY must be 0..8");
  end

  logic [CNT_W-1:0] hcnt, vcnt, h_off, v_off;
  logic             h_active, v_active, hs_raw, vs_raw;
  logic [2:0]       dly_bundle;

  always_ff @(posedge vga_clk or negedge resetn) begin
    if (!resetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
    end else begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end

  // Offsets wrap below the active start, so one unsigned compare covers both edges.
  // req_valid qualifies req_x/req_y; there is no ready: the pixel source must
  // answer every cycle's request exactly PIX_LATENCY cycles later.
  always_comb begin
    h_off       = hcnt - H_START;
    v_off       = vcnt - V_START;
    h_active    = h_off < H_ACT_N;
    v_active    = v_off < V_ACT_N;
    req_valid   = h_active && v_active;
    req_x       = req_valid ? h_off : '0;
    req_y       = req_valid ? v_off : '0;
    line_start  = (hcnt == '0);
    frame_start = (hcnt == '0) && (vcnt == '0);
    vblank      = !v_active;
    hs_raw      = hcnt < H_SYNC_N;
    vs_raw      = vcnt < V_SYNC_N;
  end

  vga_delay_line #(
    .DEPTH     (PIX_LATENCY),
    .WIDTH     (3),
    .RESET_VAL (3'b000)
  ) u_delay (
    .vga_clk (vga_clk),
    .resetn  (resetn),
    .din     ({hs_raw, vs_raw, req_valid}),
    .dout    (dly_bundle)
  );

  // Colour is gated by the delayed enable so blanking never carries RGB.
  always_ff @(posedge vga_clk or negedge resetn) begin
    if (!resetn) begin
      VGA_HS      <= ~HS_ON;
      VGA_VS      <= ~VS_ON;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
    end else begin
      VGA_HS      <= dly_bundle[2] ? HS_ON : ~HS_ON;
      VGA_VS      <= dly_bundle[1] ? VS_ON : ~VS_ON;
      VGA_BLANK_N <= dly_bundle[0];
      VGA_R       <= dly_bundle[0] ? pix_r : 8'd0;
      VGA_G       <= dly_bundle[0] ? pix_g : 8'd0;
      VGA_B       <= dly_bundle[0] ? pix_b : 8'd0;
    end
  end

  assign VGA_SYNC_N = 1'b0;
  assign VGA_CLK    = vga_clk;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and pixel-output stage; successor to the fixed 800x600 controller.
- Generates H/V counters, sync and blank for any mode given by parameters, with programmable sync polarity.
- Issues pixel-coordinate requests to an upstream pixel source of known fixed latency, and delays sync/blank so they stay aligned with the returned RGB.
- Sits between the framebuffer/pixel generator and the DAC pins (VGA_*).

Parameters:
- H_SYNC, 128, hsync pulse width in pixel clocks
- H_BP, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- V_SYNC, 4, vsync pulse width in lines
- V_BP, 23, vertical back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch
- HS_POL, 1, active level of VGA_HS (1 = positive pulse)
- VS_POL, 1, active level of VGA_VS
- PIX_LATENCY, 2, cycles from req_x/req_y to matching pix_r/g/b; legal range 0..8
- CNT_W, 11, width of counters and coordinates

Ports:
- vga_clk  in  1  pixel clock
- resetn  in  1  asynchronous, active-low reset
- pix_r  in  8  red from pixel source, valid PIX_LATENCY cycles after request
- pix_g  in  8  green, same timing
- pix_b  in  8  blue, same timing
- req_x  out  CNT_W  active-area column being requested
- req_y  out  CNT_W  active-area row being requested
- req_valid  out  1  req_x/req_y lie in the active area
- line_start  out  1  one-cycle strobe at hcnt==0
- frame_start  out  1  one-cycle strobe at hcnt==0 && vcnt==0
- vblank  out  1  vcnt is outside the active lines (request timebase)
- VGA_R  out  8  red to DAC
- VGA_G  out  8  green to DAC
- VGA_B  out  8  blue to DAC
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_BLANK_N  out  1  low outside active area
- VGA_SYNC_N  out  1  tied 0
- VGA_CLK  out  1  equals vga_clk

Behaviour:
- All sequential logic runs on posedge vga_clk. Reset is asynchronous, active-low.
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL is the vertical equivalent. Elaboration error if either total is >= 2^CNT_W or PIX_LATENCY > 8.
- hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments only when hcnt wraps, counts 0..V_TOTAL-1, wraps to 0.
- Line regions, by count: sync [0, H_SYNC); back porch; active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE); front porch. Vertical regions follow the same layout.
- Request stage (cycle t), combinational from the registered counters:
  - req_valid = h_active && v_active.
  - req_x = hcnt-(H_SYNC+H_BP) when req_valid, else 0. req_y uses the same rule with vcnt.
  - line_start, frame_start and vblank are also combinational from the counters.
- Output stage:
  - hs_raw, vs_raw and de (= req_valid) pass through a PIX_LATENCY-deep delay line, then one output register.
  - Output at cycle t+PIX_LATENCY+1 corresponds to counters at cycle t.
  - VGA_HS = hs_raw_delayed ? HS_POL : ~HS_POL. VGA_VS uses the same rule.
  - VGA_BLANK_N = de_delayed.
  - VGA_R/G/B are registered from pix_* when de_delayed, else 0. No colour is ever driven during blanking.
- Reset values:
  - hcnt, vcnt = 0; all delay stages = inactive (sync deasserted, de=0).
  - VGA_R/G/B = 0, VGA_BLANK_N = 0, VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
  - req_* and line_start/frame_start follow the counters, so they are asserted during reset: frame_start=1, line_start=1, vblank=1.
- Reset mid-frame: the raster restarts at hcnt=vcnt=0 on the first clock after release. The delay line is flushed, so no stale colour or sync reaches the pins.
- Boundaries:
  - Last pixel: hcnt=H_TOTAL-1 with vcnt=V_TOTAL-1 wraps both counters in the same cycle, and frame_start asserts the next cycle.
  - PIX_LATENCY=0: the delay line is omitted, and the output register alone gives 1-cycle latency.
  - Zero-length porch parameters are legal; the regions abut.

Decomposition:
- Package vga_pkg:
  - typedef vga_timing_t struct (sync, bp, active, fp).
  - Constants VGA_800X600_60 and VGA_640X480_60.
  - Function timing_total().
- Sub-module vga_delay_line: parametrised DEPTH/WIDTH shift register with asynchronous clear to a parameter RESET_VAL. It is instantiated once for the {hs, vs, de} bundle.

Test Plan:
1. Small mode H=2/3/8/2, V=1/2/4/1, PIX_LATENCY=2, reset released -> H_TOTAL=15, V_TOTAL=8; frame_start period exactly 120 clocks; line_start every 15.
2. Same mode, pixel model returns pix_r=req_x, pix_g=req_y after 2 cycles -> VGA_R at first visible pixel of row 3 = 0, last = 7, VGA_G = 3; RGB=0 whenever VGA_BLANK_N=0.
3. HS_POL=0, VS_POL=1 -> VGA_HS low for exactly 2 clocks per line, starting 3 clocks (PIX_LATENCY+1) after line_start; VGA_VS high for exactly 15 clocks per frame.
4. Default 800x600 parameters -> 1056 clocks/line, 628 lines/frame, 800 BLANK_N-high clocks per active line, 600 active lines.
5. Assert resetn mid-active-line (hcnt=300, vcnt=100) -> outputs immediately at reset values; after release, the first frame_start occurs 0 cycles later (hcnt=vcnt=0) and the first visible pixel appears at clock 5+3=8 of line 3.
6. PIX_LATENCY=0 and PIX_LATENCY=8 sweeps of scenario 2 -> colour/BLANK_N alignment holds (VGA_R==column index on every visible pixel).
